cam_stream_gen: RTL

OV7670-style camera transmitter: from one system clock it generates CAM_pclk, CAM_vsync, CAM_href and an 8-bit CAM_px_data byte stream carrying RGB444 pixels. It is the sending end of the camera interface that the capture block consumes. It replaces the physical camera in simulation and in on-board loopback tests, driving the capture → dual-port RAM → VGA path with known frames.

---
 rtl/cam_stream_gen.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/cam_stream_gen.sv
// OV7670-style camera transmitter: pclk = clk/2, vsync/href framing, RGB444 byte stream.
// All outputs are registered and change only on pclk falling edges, so the receiver samples stable data on pclk rising.
module cam_stream_gen #(
    parameter int WIDTH    = 160,
    parameter int HEIGHT   = 120,
    parameter int VS_PCLK  = 8,
    parameter int VBP_PCLK = 16,
    parameter int HBL_PCLK = 16,
    parameter int VFP_PCLK = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       pat_sel,
    output logic       CAM_pclk,
    output logic       CAM_vsync,
    output logic       CAM_href,
    output logic [7:0] CAM_px_data,
    output logic       frame_done,
    output logic [7:0] frame_cnt
);

    localparam int BW    = $clog2(2*WIDTH);
    localparam int LW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int BAR_W = (WIDTH/8 > 0) ? WIDTH/8 : 1;
    localparam logic [BW-1:0] LAST_BYTE = BW'(2*WIDTH-1);
    localparam logic [LW-1:0] LAST_LINE = LW'(HEIGHT-1);

    typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_VBP, S_ACTIVE, S_HBLANK, S_VFP} state_t;

    state_t          state_q, state_d;
    logic            ph_q;
    logic [BW-1:0]   byte_q, byte_d;
    logic [LW-1:0]   line_q, line_d;
    logic [7:0]      porch_q, porch_d;
    logic [14:0]     pix_q, pix_d;
    logic            pat_q, pat_d;
    logic            vsync_q, vsync_d;
    logic            href_q, href_d;
    logic [7:0]      data_q, data_d;
    logic            done_q, done_d;
    logic [7:0]      fcnt_q, fcnt_d;

    int              x_pix;
    logic [2:0]      bar;
    logic [11:0]     rgb;

    function automatic logic [11:0] bar_rgb(input logic [2:0] b);
        case (b)
            3'd0:    bar_rgb = 12'hFFF;
            3'd1:    bar_rgb = 12'hFF0;
            3'd2:    bar_rgb = 12'h0FF;
            3'd3:    bar_rgb = 12'h0F0;
            3'd4:    bar_rgb = 12'hF0F;
            3'd5:    bar_rgb = 12'hF00;
            3'd6:    bar_rgb = 12'h00F;
            default: bar_rgb = 12'h000;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        byte_d  = byte_q;
        line_d  = line_q;
        porch_d = porch_q;
        pix_d   = pix_q;
        pat_d   = pat_q;
        fcnt_d  = fcnt_q;
        done_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (en) begin
                    state_d = S_VSYNC;
                    pat_d   = pat_sel;
                    line_d  = '0;
                    pix_d   = '0;
                    porch_d = '0;
                end
            end
            S_VSYNC: begin
                if (porch_q == 8'(VS_PCLK-1)) begin
                    state_d = S_VBP;
                    porch_d = '0;
                end else begin
                    porch_d = porch_q + 8'd1;
                end
            end
            S_VBP: begin
                if (porch_q == 8'(VBP_PCLK-1)) begin
                    state_d = S_ACTIVE;
                    byte_d  = '0;
                end else begin
                    porch_d = porch_q + 8'd1;
                end
            end
            S_ACTIVE: begin
                // the pixel index advances once the odd (G/B) byte has gone out
                if (byte_q[0]) pix_d = pix_q + 15'd1;
                if (byte_q == LAST_BYTE) begin
                    state_d = S_HBLANK;
                    porch_d = '0;
                end else begin
                    byte_d = byte_q + BW'(1);
                end
            end
            S_HBLANK: begin
                if (porch_q == 8'(HBL_PCLK-1)) begin
                    porch_d = '0;
                    if (line_q == LAST_LINE) begin
                        state_d = S_VFP;
                    end else begin
                        state_d = S_ACTIVE;
                        line_d  = line_q + LW'(1);
                        byte_d  = '0;
                    end
                end else begin
                    porch_d = porch_q + 8'd1;
                end
            end
            S_VFP: begin
                if (porch_q == 8'(VFP_PCLK-1)) begin
                    done_d  = 1'b1;
                    fcnt_d  = fcnt_q + 8'd1;
                    porch_d = '0;
                    if (en) begin
                        state_d = S_VSYNC;
                        pat_d   = pat_sel;
                        line_d  = '0;
                        pix_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    porch_d = porch_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // output bytes are derived from the next-state counters so they register alongside them
        x_pix   = int'(byte_d[BW-1:1]);
        bar     = (x_pix / BAR_W > 7) ? 3'd7 : 3'(x_pix / BAR_W);
        rgb     = pat_d ? pix_d[11:0] : bar_rgb(bar);
        vsync_d = (state_d == S_VSYNC);
        href_d  = (state_d == S_ACTIVE);
        data_d  = 8'h00;
        if (href_d) data_d = byte_d[0] ? rgb[7:0] : {4'b0000, rgb[11:8]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ph_q    <= 1'b0;
            state_q <= S_IDLE;
            byte_q  <= '0;
            line_q  <= '0;
            porch_q <= '0;
            pix_q   <= '0;
            pat_q   <= 1'b0;
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            ph_q   <= ~ph_q;
            done_q <= ph_q & done_d;
            if (ph_q) begin
                state_q <= state_d;
                byte_q  <= byte_d;
                line_q  <= line_d;
                porch_q <= porch_d;
                pix_q   <= pix_d;
                pat_q   <= pat_d;
                vsync_q <= vsync_d;
                href_q  <= href_d;
                data_q  <= data_d;
                fcnt_q  <= fcnt_d;
            end
        end
    end

    assign CAM_pclk    = ph_q;
    assign CAM_vsync   = vsync_q;
    assign CAM_href    = href_q;
    assign CAM_px_data = data_q;
    assign frame_done  = done_q;
    assign frame_cnt   = fcnt_q;

endmodule
